// File: rtl/aes_dma_pkg.sv
// Shared types for the AES DMA buffer manager.
// Transfer FSM states and packet-length helper.
package aes_dma_pkg;

   localparam int PKT_WORDS = 4;
   localparam int LEN_W     = 6;

   typedef enum logic [2:0] {
      IDLE,
      CHK,
      PREF,
      REQ,
      XFER,
      DONE,
      ERR
   } dma_state_e;

   function automatic logic [LEN_W-1:0] pkt_len(input logic [LEN_W-1:0] pkts_m1);
      return (pkts_m1 + LEN_W'(1)) * LEN_W'(PKT_WORDS);
   endfunction

endpackage

// File: rtl/aes_dma_bank.sv
// One packet buffer: 2**AW x 32, one write port, one sync read port.
// Behavioural stand-in for the Mem1R1W16x32 macro.
module aes_dma_bank
   import aes_dma_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ScanMode,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [2**AW];
   logic [31:0] rdata_d, rdata_q;
   logic        unused_scan;

   assign unused_scan = ScanMode;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   // Output register holds its value until the next read strobe.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/aes_dma_bufmgr.sv
// Ping-pong packet buffers between the AES core and the fla_hbm port.
// Burst load/store FSM with prefetch, address checking and sticky error.
module aes_dma_bufmgr
   import aes_dma_pkg::*;
#(
   parameter int NBANK = 2,
   parameter int AW    = 4,
   parameter int BW    = $clog2(NBANK),
   parameter int SW    = AW - 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ScanMode,
   input  logic [SW-1:0] DmaSize,
   input  logic [27:0]   MemAdd,
   input  logic [BW-1:0] MemBank,
   input  logic          MemIrdy,
   input  logic          MemRd_Wr,
   output logic          MemTrdy,
   output logic          dma_ahb_err,
   input  logic          ErrClr,
   output logic          Busy,
   input  logic [BW-1:0] AesBank,
   input  logic          AesWr,
   input  logic          AesRd,
   input  logic [AW-1:0] AesWrAdd,
   input  logic [AW-1:0] AesRdAdd,
   input  logic [31:0]   AesWrData,
   output logic [31:0]   AesRdData,
   output logic          f2m_req,
   output logic          f2m_write,
   output logic [23:0]   f2m_addr,
   output logic [5:0]    f2m_len,
   output logic [31:0]   dma_hwdata_o,
   input  logic          m2f_ack,
   input  logic          m2f_fwvalid,
   input  logic          m2f_frvalid,
   input  logic          m2f_viol,
   input  logic [31:0]   dma_hrdata_i
);

   dma_state_e       state_d, state_q;
   logic             irdy_d, irdy_q;
   logic [BW-1:0]    bank_d, bank_q;
   logic             dir_d, dir_q;
   logic [27:0]      addr_d, addr_q;
   logic [LEN_W-1:0] len_d, len_q;
   logic [LEN_W-1:0] ptr_d, ptr_q;
   logic             req_d, req_q;
   logic             trdy_d, trdy_q;
   logic             err_d, err_q;
   logic             aes_ok_d, aes_ok_q;
   logic [BW-1:0]    aes_bank_d, aes_bank_q;

   logic             busy;
   logic             more;
   logic             dma_we;
   logic             dma_re;
   logic [AW-1:0]    dma_raddr;
   logic [NBANK-1:0] own;
   logic [NBANK-1:0] bk_we;
   logic [NBANK-1:0] bk_re;
   logic [AW-1:0]    bk_waddr [NBANK];
   logic [AW-1:0]    bk_raddr [NBANK];
   logic [31:0]      bk_wdata [NBANK];
   logic [31:0]      bk_rdata [NBANK];

   assign busy = (state_q != IDLE);
   assign more = (ptr_q < len_q);

   always_comb begin
      state_d   = state_q;
      irdy_d    = MemIrdy;
      bank_d    = bank_q;
      dir_d     = dir_q;
      addr_d    = addr_q;
      len_d     = len_q;
      ptr_d     = ptr_q;
      req_d     = req_q;
      trdy_d    = 1'b0;
      err_d     = err_q & ~ErrClr;
      dma_we    = 1'b0;
      dma_re    = 1'b0;
      dma_raddr = ptr_q[AW-1:0];
      unique case (state_q)
         IDLE: begin
            // Transfer parameters are captured with the start edge.
            if (MemIrdy && !irdy_q) begin
               state_d = CHK;
               bank_d  = MemBank;
               dir_d   = MemRd_Wr;
               addr_d  = MemAdd;
               len_d   = pkt_len(LEN_W'(DmaSize));
            end
         end
         CHK: begin
            if (addr_q[1:0] != 2'd0 || addr_q[27:26] != 2'd0)
               state_d = ERR;
            else if (dir_q)
               state_d = REQ;
            else
               state_d = PREF;
         end
         PREF: begin
            dma_re    = 1'b1;
            dma_raddr = '0;
            ptr_d     = LEN_W'(1);
            state_d   = REQ;
         end
         REQ: begin
            req_d   = 1'b1;
            state_d = XFER;
         end
         XFER: begin
            if (more && dir_q && m2f_fwvalid) begin
               dma_we = 1'b1;
               ptr_d  = ptr_q + LEN_W'(1);
            end
            // Last store beat needs no follow-on read; avoids wrapping to word 0.
            if (!dir_q && m2f_frvalid && more) begin
               dma_re = 1'b1;
               ptr_d  = ptr_q + LEN_W'(1);
            end
            if (m2f_ack) begin
               req_d   = 1'b0;
               state_d = m2f_viol ? ERR : DONE;
            end
         end
         DONE: begin
            trdy_d  = 1'b1;
            ptr_d   = '0;
            state_d = IDLE;
         end
         ERR: begin
            trdy_d  = 1'b1;
            req_d   = 1'b0;
            ptr_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      aes_bank_d = aes_bank_q;
      aes_ok_d   = AesRd && !own[AesBank];
      if (AesRd) aes_bank_d = AesBank;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         irdy_q     <= 1'b0;
         bank_q     <= '0;
         dir_q      <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         ptr_q      <= '0;
         req_q      <= 1'b0;
         trdy_q     <= 1'b0;
         err_q      <= 1'b0;
         aes_ok_q   <= 1'b0;
         aes_bank_q <= '0;
      end else begin
         state_q    <= state_d;
         irdy_q     <= irdy_d;
         bank_q     <= bank_d;
         dir_q      <= dir_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         ptr_q      <= ptr_d;
         req_q      <= req_d;
         trdy_q     <= trdy_d;
         err_q      <= err_d;
         aes_ok_q   <= aes_ok_d;
         aes_bank_q <= aes_bank_d;
      end
   end

   for (genvar i = 0; i < NBANK; i++) begin : g_bank
      assign own[i]      = busy && (bank_q == BW'(i));
      assign bk_we[i]    = own[i] ? dma_we : (AesWr && AesBank == BW'(i));
      assign bk_re[i]    = own[i] ? dma_re : (AesRd && AesBank == BW'(i));
      assign bk_waddr[i] = own[i] ? ptr_q[AW-1:0] : AesWrAdd;
      assign bk_raddr[i] = own[i] ? dma_raddr : AesRdAdd;
      assign bk_wdata[i] = own[i] ? dma_hrdata_i : AesWrData;

      aes_dma_bank #(
         .AW(AW)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .ScanMode(ScanMode),
         .we      (bk_we[i]),
         .waddr   (bk_waddr[i]),
         .wdata   (bk_wdata[i]),
         .re      (bk_re[i]),
         .raddr   (bk_raddr[i]),
         .rdata   (bk_rdata[i])
      );
   end

   assign MemTrdy      = trdy_q;
   assign dma_ahb_err  = err_q;
   assign Busy         = busy;
   assign f2m_req      = req_q;
   assign f2m_write    = dir_q;
   assign f2m_addr     = addr_q[25:2];
   assign f2m_len      = len_q;
   assign AesRdData    = aes_ok_q ? bk_rdata[aes_bank_q] : '0;
   assign dma_hwdata_o = (!dir_q && (state_q == REQ || state_q == XFER))
                         ? bk_rdata[bank_q] : '0;

endmodule

// File: tb/tb_aes_dma_bufmgr.sv
// Scenario bench for aes_dma_bufmgr with a data scoreboard queue.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_aes_dma_bufmgr;

   logic        clk = 1'b0;
   logic        rst;
   logic        ScanMode;
   logic [1:0]  DmaSize;
   logic [27:0] MemAdd;
   logic [0:0]  MemBank;
   logic        MemIrdy;
   logic        MemRd_Wr;
   logic        MemTrdy;
   logic        dma_ahb_err;
   logic        ErrClr;
   logic        Busy;
   logic [0:0]  AesBank;
   logic        AesWr;
   logic        AesRd;
   logic [3:0]  AesWrAdd;
   logic [3:0]  AesRdAdd;
   logic [31:0] AesWrData;
   logic [31:0] AesRdData;
   logic        f2m_req;
   logic        f2m_write;
   logic [23:0] f2m_addr;
   logic [5:0]  f2m_len;
   logic [31:0] dma_hwdata_o;
   logic        m2f_ack;
   logic        m2f_fwvalid;
   logic        m2f_frvalid;
   logic        m2f_viol;
   logic [31:0] dma_hrdata_i;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];

   aes_dma_bufmgr #(.NBANK(2), .AW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .ScanMode    (ScanMode),
      .DmaSize     (DmaSize),
      .MemAdd      (MemAdd),
      .MemBank     (MemBank),
      .MemIrdy     (MemIrdy),
      .MemRd_Wr    (MemRd_Wr),
      .MemTrdy     (MemTrdy),
      .dma_ahb_err (dma_ahb_err),
      .ErrClr      (ErrClr),
      .Busy        (Busy),
      .AesBank     (AesBank),
      .AesWr       (AesWr),
      .AesRd       (AesRd),
      .AesWrAdd    (AesWrAdd),
      .AesRdAdd    (AesRdAdd),
      .AesWrData   (AesWrData),
      .AesRdData   (AesRdData),
      .f2m_req     (f2m_req),
      .f2m_write   (f2m_write),
      .f2m_addr    (f2m_addr),
      .f2m_len     (f2m_len),
      .dma_hwdata_o(dma_hwdata_o),
      .m2f_ack     (m2f_ack),
      .m2f_fwvalid (m2f_fwvalid),
      .m2f_frvalid (m2f_frvalid),
      .m2f_viol    (m2f_viol),
      .dma_hrdata_i(dma_hrdata_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [0:0] bank, input logic dir,
                        input logic [1:0] size, input logic [27:0] addr);
      MemBank  = bank;
      MemRd_Wr = dir;
      DmaSize  = size;
      MemAdd   = addr;
      MemIrdy  = 1'b1;
      clk1();
      MemIrdy  = 1'b0;
   endtask

   task automatic wait_req(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (f2m_req) begin
            seen = 1'b1;
            break;
         end
         clk1();
      end
   endtask

   task automatic wait_trdy(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (MemTrdy) begin
            seen = 1'b1;
            break;
         end
         clk1();
      end
   endtask

   task automatic ack_once(input logic viol);
      m2f_ack  = 1'b1;
      m2f_viol = viol;
      clk1();
      m2f_ack  = 1'b0;
      m2f_viol = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clk1();
      clk1();
      rst = 1'b0;
      clk1();
      checks++;
      if ({f2m_req, MemTrdy, dma_ahb_err, Busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b exp 0000",
                  {f2m_req, MemTrdy, dma_ahb_err, Busy});
      end
      checks++;
      if (dma_hwdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_hwdata: got %h exp 0", dma_hwdata_o);
      end
   endtask

   task automatic test_aes_access();
      AesBank = 1'b0;
      for (int i = 0; i < 16; i++) begin
         AesWr     = 1'b1;
         AesWrAdd  = 4'(i);
         AesWrData = 32'hA0 + 32'(i);
         clk1();
      end
      AesWr = 1'b0;
      for (int i = 3; i < 16; i += 12) begin
         exp_q.push_back(32'hA0 + 32'(i));
         AesRd    = 1'b1;
         AesRdAdd = 4'(i);
         clk1();
         AesRd = 1'b0;
         checks++;
         if (AesRdData !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL aes_read word%0d: got %h", i, AesRdData);
         end
      end
   endtask

   task automatic test_load();
      bit seen;
      start(1'b1, 1'b1, 2'd3, 28'h100);
      wait_req(seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL load_req: no f2m_req within budget");
      end
      checks++;
      if ({f2m_addr, f2m_len, f2m_write, Busy} !== {24'h40, 6'd16, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL load_cmd: addr %h len %0d wr %b busy %b exp 40/16/1/1",
                  f2m_addr, f2m_len, f2m_write, Busy);
      end
      for (int i = 0; i < 18; i++) begin
         m2f_fwvalid  = 1'b1;
         dma_hrdata_i = (i < 16) ? 32'h1000 + 32'(i) : 32'hDEAD;
         if (i < 16) exp_q.push_back(dma_hrdata_i);
         clk1();
      end
      m2f_fwvalid = 1'b0;
      ack_once(1'b0);
      wait_trdy(seen);
      checks++;
      if (!seen || dma_ahb_err !== 1'b0 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL load_done: trdy %b err %b busy %b exp 1/0/0",
                  seen, dma_ahb_err, Busy);
      end
      AesBank = 1'b1;
      for (int i = 0; i < 16; i++) begin
         AesRd    = 1'b1;
         AesRdAdd = 4'(i);
         clk1();
         checks++;
         if (AesRdData !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL load_word%0d: got %h", i, AesRdData);
         end
      end
      AesRd = 1'b0;
   endtask

   task automatic test_store();
      bit          seen;
      logic [31:0] pre_hw;
      pre_hw = 32'hX;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + 32'(i));
      start(1'b0, 1'b0, 2'd1, 28'h200);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (f2m_req) begin
            seen = 1'b1;
            break;
         end
         pre_hw = dma_hwdata_o;
         clk1();
      end
      checks++;
      if (!seen || pre_hw !== 32'hA0 || f2m_write !== 1'b0) begin
         errors++;
         $display("FAIL store_prefetch: req %b hw %h wr %b exp 1/a0/0",
                  seen, pre_hw, f2m_write);
      end
      for (int i = 0; i < 9; i++) begin
         m2f_frvalid = (i != 4);
         if (m2f_frvalid) begin
            checks++;
            if (dma_hwdata_o !== exp_q.pop_front()) begin
               errors++;
               $display("FAIL store_beat%0d: got %h", i, dma_hwdata_o);
            end
         end
         clk1();
      end
      m2f_frvalid = 1'b0;
      ack_once(1'b0);
      wait_trdy(seen);
      checks++;
      if (!seen || dma_ahb_err !== 1'b0) begin
         errors++;
         $display("FAIL store_done: trdy %b err %b exp 1/0", seen, dma_ahb_err);
      end
   endtask

   task automatic test_ownership();
      bit seen;
      start(1'b0, 1'b1, 2'd0, 28'h0);
      AesBank = 1'b0; AesWr = 1'b1; AesWrAdd = 4'd5; AesWrData = 32'hBAD;
      clk1();
      AesBank = 1'b1; AesWrAdd = 4'd7; AesWrData = 32'h77;
      clk1();
      AesWr = 1'b0;
      AesBank = 1'b0; AesRd = 1'b1; AesRdAdd = 4'd0;
      clk1();
      checks++;
      if (AesRdData !== 32'h0 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL own_locked_read: got %h busy %b exp 0/1", AesRdData, Busy);
      end
      AesBank = 1'b1; AesRdAdd = 4'd7;
      clk1();
      AesRd = 1'b0;
      checks++;
      if (AesRdData !== 32'h77) begin
         errors++;
         $display("FAIL own_other_bank: got %h exp 77", AesRdData);
      end
      wait_req(seen);
      for (int i = 0; i < 4; i++) begin
         m2f_fwvalid  = 1'b1;
         dma_hrdata_i = 32'hC0 + 32'(i);
         exp_q.push_back(dma_hrdata_i);
         clk1();
      end
      m2f_fwvalid = 1'b0;
      ack_once(1'b0);
      wait_trdy(seen);
      clk1();
      exp_q.push_back(32'hA5);
      AesBank = 1'b0;
      for (int i = 0; i < 5; i++) begin
         AesRd    = 1'b1;
         AesRdAdd = (i < 4) ? 4'(i) : 4'd5;
         clk1();
         checks++;
         if (AesRdData !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL own_bank0 addr%0d: got %h", AesRdAdd, AesRdData);
         end
      end
      AesRd = 1'b0;
   endtask

   task automatic test_viol();
      bit seen;
      start(1'b1, 1'b1, 2'd1, 28'h40);
      wait_req(seen);
      for (int i = 0; i < 5; i++) begin
         m2f_fwvalid  = 1'b1;
         dma_hrdata_i = 32'h500 + 32'(i);
         m2f_ack      = (i == 4);
         m2f_viol     = (i == 4);
         clk1();
      end
      {m2f_fwvalid, m2f_ack, m2f_viol} = 3'b000;
      wait_trdy(seen);
      checks++;
      if (!seen || dma_ahb_err !== 1'b1 || Busy !== 1'b0 || f2m_req !== 1'b0) begin
         errors++;
         $display("FAIL viol_abort: trdy %b err %b busy %b req %b exp 1/1/0/0",
                  seen, dma_ahb_err, Busy, f2m_req);
      end
      clk1();
      checks++;
      if (MemTrdy !== 1'b0 || dma_ahb_err !== 1'b1) begin
         errors++;
         $display("FAIL viol_sticky: trdy %b err %b exp 0/1", MemTrdy, dma_ahb_err);
      end
      ErrClr = 1'b1;
      clk1();
      ErrClr = 1'b0;
      checks++;
      if (dma_ahb_err !== 1'b0) begin
         errors++;
         $display("FAIL viol_clear: got %b exp 0", dma_ahb_err);
      end
   endtask

   task automatic test_addr_err();
      logic [27:0] bad [2];
      bad[0] = 28'h102;
      bad[1] = 28'h4000000;
      for (int k = 0; k < 2; k++) begin
         ErrClr = (k == 1);
         start(1'b0, 1'b1, 2'd0, bad[k]);
         clk1();
         checks++;
         if (f2m_req !== 1'b0 || MemTrdy !== 1'b0) begin
            errors++;
            $display("FAIL adderr%0d_early: req %b trdy %b exp 0/0", k, f2m_req, MemTrdy);
         end
         clk1();
         checks++;
         if ({MemTrdy, dma_ahb_err, f2m_req, Busy} !== 4'b1100) begin
            errors++;
            $display("FAIL adderr%0d_flag: trdy/err/req/busy %b exp 1100",
                     k, {MemTrdy, dma_ahb_err, f2m_req, Busy});
         end
         ErrClr = 1'b1;
         clk1();
         ErrClr = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      start(1'b1, 1'b1, 2'd3, 28'h100);
      wait_req(seen);
      for (int i = 0; i < 3; i++) begin
         m2f_fwvalid  = 1'b1;
         dma_hrdata_i = 32'h900 + 32'(i);
         if (i < 2) clk1();
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({f2m_req, Busy, MemTrdy} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid: req/busy/trdy %b exp 000", {f2m_req, Busy, MemTrdy});
      end
      m2f_fwvalid = 1'b0;
      clk1();
      rst = 1'b0;
      clk1();
      start(1'b1, 1'b1, 2'd0, 28'h10);
      wait_req(seen);
      checks++;
      if (!seen || f2m_addr !== 24'h4 || f2m_len !== 6'd4) begin
         errors++;
         $display("FAIL rst_rerun_cmd: req %b addr %h len %0d exp 1/4/4",
                  seen, f2m_addr, f2m_len);
      end
      for (int i = 0; i < 4; i++) begin
         m2f_fwvalid  = 1'b1;
         dma_hrdata_i = 32'hE0 + 32'(i);
         exp_q.push_back(dma_hrdata_i);
         clk1();
      end
      m2f_fwvalid = 1'b0;
      ack_once(1'b0);
      wait_trdy(seen);
      checks++;
      if (!seen || dma_ahb_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_rerun_done: trdy %b err %b exp 1/0", seen, dma_ahb_err);
      end
      AesBank = 1'b1;
      for (int i = 0; i < 4; i++) begin
         AesRd    = 1'b1;
         AesRdAdd = 4'(i);
         clk1();
         checks++;
         if (AesRdData !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL rst_rerun_word%0d: got %h", i, AesRdData);
         end
      end
      AesRd = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      ScanMode     = 1'b0;
      DmaSize      = '0;
      MemAdd       = '0;
      MemBank      = '0;
      MemIrdy      = 1'b0;
      MemRd_Wr     = 1'b0;
      ErrClr       = 1'b0;
      AesBank      = '0;
      AesWr        = 1'b0;
      AesRd        = 1'b0;
      AesWrAdd     = '0;
      AesRdAdd     = '0;
      AesWrData    = '0;
      m2f_ack      = 1'b0;
      m2f_fwvalid  = 1'b0;
      m2f_frvalid  = 1'b0;
      m2f_viol     = 1'b0;
      dma_hrdata_i = '0;
      test_reset();
      test_aes_access();
      test_load();
      test_store();
      test_ownership();
      test_viol();
      test_addr_err();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
